cxu_req_arbiter: RTL and testbench
==================================

Name: cxu_req_arbiter

Overview:
- Shares the single CXU request/response channel of a core tile between NUM_REQ requesters, e.g. several cva5 instances or a core plus a DMA-side CXU user.
- Round-robin arbitration onto one registered request port.
- Rewrites each request ID to an internal tag and routes each response back to its requester with the original ID restored.
- Sits between the requesters' cxu_interface instances and the exported cxu_req_*/cxu_resp_* pins.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- REQ_ID_W, 3, request ID width; the tag table holds 2**REQ_ID_W entries
- CXU_ID_W, 4, CXU select width
- STATE_ID_W, 2, state context width
- FUNC_ID_W, 10, function ID width
- INSN_W, 32, instruction width
- DATA_W, 32, operand/result width
- STATUS_W, 1, response status width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_req_valid  in  NUM_REQ  per-requester request valid
- s_req_ready  out  NUM_REQ  per-requester request ready
- s_req_id  in  NUM_REQ*REQ_ID_W  original request IDs, requester i in slice i
- s_req_payload  in  NUM_REQ*(CXU_ID_W+STATE_ID_W+FUNC_ID_W+INSN_W+2*DATA_W)  {cxu,state,func,insn,data0,data1}
- m_req_valid  out  1  shared request valid
- m_req_ready  in  1  shared request ready
- m_req_id  out  REQ_ID_W  internal tag
- m_req_payload  out  same as one s_req_payload slice  forwarded payload
- m_resp_valid  in  1  shared response valid
- m_resp_ready  out  1  shared response ready
- m_resp_id  in  REQ_ID_W  tag of response
- m_resp_status  in  STATUS_W  status
- m_resp_data  in  DATA_W  result
- s_resp_valid  out  NUM_REQ  routed response valid
- s_resp_ready  in  NUM_REQ  requester response ready
- s_resp_id  out  REQ_ID_W  restored original ID, broadcast to all requesters
- s_resp_status  out  STATUS_W  broadcast
- s_resp_data  out  DATA_W  broadcast
- outstanding  out  REQ_ID_W+1  allocated tag count
- err_unexpected_resp  out  1  sticky: a response arrived for an unallocated tag

Behaviour:
- Reset (async, rst_n=0):
  - m_req_valid=0 and all tag entries invalid.
  - Round-robin pointer=0, outstanding=0, err_unexpected_resp=0.
  - All s_req_ready and s_resp_valid=0.
  - Mid-operation reset abandons in-flight tags silently.
- Tag table:
  - Each entry holds {valid, owner index, original id}.
  - Free tag = lowest-index invalid entry, computed from registered state only.
  - A tag freed in a cycle is not reallocated in that same cycle.
- Accept condition: load = (!m_req_valid || m_req_ready) && free tag exists.
- Request ready:
  - s_req_ready[i] = load && grant[i].
  - If the table is full, all s_req_ready=0.
- Grant:
  - Round-robin among s_req_valid, starting at the pointer.
  - On an accepted handshake the pointer moves to granted index +1, mod NUM_REQ; otherwise it holds.
- Allocation on handshake:
  - Payload and tag register into the output stage; m_req_valid=1 next cycle (1-cycle latency).
  - The entry becomes valid with {owner, s_req_id}.
- Output stage:
  - m_req_* hold stable while m_req_valid && !m_req_ready.
  - On ready with no new load, m_req_valid drops to 0.
  - Back-to-back throughput: 1 request/cycle when m_req_ready=1 and tags are free.
- Response routing (combinational):
  - Entry e = table[m_resp_id].
  - If e.valid: s_resp_valid[e.owner]=m_resp_valid, m_resp_ready=s_resp_ready[e.owner], s_resp_id=e.id; status and data pass through.
  - On handshake, entry e is invalidated at the clock edge.
- Unexpected response:
  - If !e.valid: m_resp_ready=1, response dropped, no s_resp_valid.
  - err_unexpected_resp set at the edge and held until reset.
- Simultaneous allocate and free of different tags in one cycle:
  - Both take effect.
  - outstanding = outstanding + alloc - free (+0 when both occur).
- Ordering: responses may return in any order; routing depends only on the tag.

Test Plan:
- Single requester 0, id=5, data0=0x11: m_req_valid next cycle with tag 0 and payload intact; m_resp_id=0, data=0xABCD → s_resp_valid[0]=1, s_resp_id=5, outstanding 1→0.
- Requesters 0 and 1 both valid continuously, m_req_ready=1: grants alternate 0,1,0,1 with tags 0,1,2,3; one issue per cycle.
- m_req_ready=0 for 3 cycles with a request pending: m_req_* stable, all s_req_ready=0, pointer unchanged.
- 8 requests with no responses: outstanding=8 and s_req_ready=0. Then respond with tag 3 → the next request gets tag 3 one cycle after the free, not in the same cycle.
- Responses out of order (tag 1 then tag 0, owners 1 and 0, s_resp_ready[1]=0 for 2 cycles): m_resp_ready=0 while stalled; each response delivered to the correct owner with its original ID.
- m_resp_valid with m_resp_id=6 unallocated: m_resp_ready=1, no s_resp_valid, err_unexpected_resp=1 held. rst_n low mid-traffic: all outputs return to reset values immediately.

Source files
------------

// File: rtl/cxu_req_arbiter.sv
// Shares one CXU request/response channel between NUM_REQ requesters.
// Requests are granted round-robin into a registered output stage. Each
// request's ID is swapped for an internal tag, and the tag table restores the
// original ID when the response comes back. Routing back to the requester
// depends only on the tag, so responses may return in any order.
module cxu_req_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int REQ_ID_W   = 3,
   parameter int CXU_ID_W   = 4,
   parameter int STATE_ID_W = 2,
   parameter int FUNC_ID_W  = 10,
   parameter int INSN_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STATUS_W   = 1,
   localparam int PAY_W     = CXU_ID_W + STATE_ID_W + FUNC_ID_W + INSN_W + 2*DATA_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           s_req_valid,
   output logic [NUM_REQ-1:0]           s_req_ready,
   input  logic [NUM_REQ*REQ_ID_W-1:0]  s_req_id,
   input  logic [NUM_REQ*PAY_W-1:0]     s_req_payload,
   output logic                         m_req_valid,
   input  logic                         m_req_ready,
   output logic [REQ_ID_W-1:0]          m_req_id,
   output logic [PAY_W-1:0]             m_req_payload,
   input  logic                         m_resp_valid,
   output logic                         m_resp_ready,
   input  logic [REQ_ID_W-1:0]          m_resp_id,
   input  logic [STATUS_W-1:0]          m_resp_status,
   input  logic [DATA_W-1:0]            m_resp_data,
   output logic [NUM_REQ-1:0]           s_resp_valid,
   input  logic [NUM_REQ-1:0]           s_resp_ready,
   output logic [REQ_ID_W-1:0]          s_resp_id,
   output logic [STATUS_W-1:0]          s_resp_status,
   output logic [DATA_W-1:0]            s_resp_data,
   output logic [REQ_ID_W:0]            outstanding,
   output logic                         err_unexpected_resp
);

   localparam int NTAG  = 2**REQ_ID_W;
   localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = REQ_ID_W + 1;

   logic [NTAG-1:0]     tag_vld_q, tag_vld_d;
   logic [OWN_W-1:0]    tag_own_q [NTAG];
   logic [OWN_W-1:0]    tag_own_d [NTAG];
   logic [REQ_ID_W-1:0] tag_id_q  [NTAG];
   logic [REQ_ID_W-1:0] tag_id_d  [NTAG];
   logic [OWN_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                m_req_valid_q, m_req_valid_d;
   logic [REQ_ID_W-1:0] m_req_id_q, m_req_id_d;
   logic [PAY_W-1:0]    m_req_payload_q, m_req_payload_d;
   logic [CNT_W-1:0]    outstanding_q, outstanding_d;
   logic                err_q, err_d;

   logic                free_ok;
   logic [REQ_ID_W-1:0] free_tag;
   logic                out_free;
   logic                load;
   logic                gnt_ok;
   logic [OWN_W-1:0]    gnt_idx;
   logic [PAY_W-1:0]    gnt_payload;
   logic [REQ_ID_W-1:0] gnt_id;
   logic                req_hs;
   logic                e_vld;
   logic [OWN_W-1:0]    e_own;
   logic                resp_free;
   logic                resp_drop;

   // Free tag and round-robin grant; both look only at registered state so a
   // tag released this cycle cannot be handed out until the next one.
   always_comb begin
      int r;
      r        = 0;
      free_ok  = 1'b0;
      free_tag = '0;
      for (int t = NTAG-1; t >= 0; t--) begin
         if (!tag_vld_q[t]) begin
            free_ok  = 1'b1;
            free_tag = REQ_ID_W'(t);
         end
      end
      gnt_ok  = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         r = int'(rr_ptr_q) + k;
         if (r >= NUM_REQ) r = r - NUM_REQ;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_ok && (i == r) && s_req_valid[i]) begin
               gnt_ok  = 1'b1;
               gnt_idx = OWN_W'(i);
            end
         end
      end
      gnt_payload = '0;
      gnt_id      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == OWN_W'(i)) begin
            gnt_payload = s_req_payload[i*PAY_W +: PAY_W];
            gnt_id      = s_req_id[i*REQ_ID_W +: REQ_ID_W];
         end
      end
      // rst_n gate keeps every ready low while reset is held
      out_free = !m_req_valid_q || m_req_ready;
      load     = rst_n && out_free && free_ok;
      req_hs   = load && gnt_ok;
      for (int i = 0; i < NUM_REQ; i++) begin
         s_req_ready[i] = req_hs && (gnt_idx == OWN_W'(i));
      end
   end

   // Response routing by tag; responses to unallocated tags are swallowed
   always_comb begin
      e_vld        = tag_vld_q[m_resp_id];
      e_own        = tag_own_q[m_resp_id];
      s_resp_id    = tag_id_q[m_resp_id];
      s_resp_valid = '0;
      m_resp_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (e_vld && (e_own == OWN_W'(i))) begin
            s_resp_valid[i] = m_resp_valid;
            m_resp_ready    = s_resp_ready[i];
         end
      end
      resp_free = m_resp_valid && m_resp_ready && e_vld;
      resp_drop = m_resp_valid && !e_vld;
   end

   // Next state for the tag table, output stage, pointer and counters
   always_comb begin
      tag_vld_d       = tag_vld_q;
      tag_own_d       = tag_own_q;
      tag_id_d        = tag_id_q;
      rr_ptr_d        = rr_ptr_q;
      m_req_valid_d   = m_req_valid_q;
      m_req_id_d      = m_req_id_q;
      m_req_payload_d = m_req_payload_q;
      outstanding_d   = outstanding_q + CNT_W'(req_hs) - CNT_W'(resp_free);
      err_d           = err_q | resp_drop;
      if (resp_free) tag_vld_d[m_resp_id] = 1'b0;
      if (out_free) m_req_valid_d = req_hs;
      if (req_hs) begin
         tag_vld_d[free_tag] = 1'b1;
         tag_own_d[free_tag] = gnt_idx;
         tag_id_d[free_tag]  = gnt_id;
         m_req_id_d          = free_tag;
         m_req_payload_d     = gnt_payload;
         rr_ptr_d            = (gnt_idx == OWN_W'(NUM_REQ-1)) ? '0 : gnt_idx + OWN_W'(1);
      end
   end

   // State registers; reset drops all in-flight tags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld_q <= '0;
         for (int t = 0; t < NTAG; t++) begin
            tag_own_q[t] <= '0;
            tag_id_q[t]  <= '0;
         end
         rr_ptr_q        <= '0;
         m_req_valid_q   <= 1'b0;
         m_req_id_q      <= '0;
         m_req_payload_q <= '0;
         outstanding_q   <= '0;
         err_q           <= 1'b0;
      end else begin
         tag_vld_q       <= tag_vld_d;
         tag_own_q       <= tag_own_d;
         tag_id_q        <= tag_id_d;
         rr_ptr_q        <= rr_ptr_d;
         m_req_valid_q   <= m_req_valid_d;
         m_req_id_q      <= m_req_id_d;
         m_req_payload_q <= m_req_payload_d;
         outstanding_q   <= outstanding_d;
         err_q           <= err_d;
      end
   end

   assign m_req_valid         = m_req_valid_q;
   assign m_req_id            = m_req_id_q;
   assign m_req_payload       = m_req_payload_q;
   assign s_resp_status       = m_resp_status;
   assign s_resp_data         = m_resp_data;
   assign outstanding         = outstanding_q;
   assign err_unexpected_resp = err_q;

endmodule

// File: tb/tb_cxu_req_arbiter.sv
// Bench for cxu_req_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_cxu_req_arbiter;
   localparam int NUM_REQ = 2;
   localparam int RW      = 3;
   localparam int PAY_W   = 112;
   localparam int NTAG    = 8;
   localparam int DW      = 32;
   localparam int SW      = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic [NUM_REQ-1:0]       s_req_valid, s_req_ready;
   logic [NUM_REQ*RW-1:0]    s_req_id;
   logic [NUM_REQ*PAY_W-1:0] s_req_payload;
   logic                     m_req_valid, m_req_ready;
   logic [RW-1:0]            m_req_id;
   logic [PAY_W-1:0]         m_req_payload;
   logic                     m_resp_valid, m_resp_ready;
   logic [RW-1:0]            m_resp_id;
   logic [SW-1:0]            m_resp_status;
   logic [DW-1:0]            m_resp_data;
   logic [NUM_REQ-1:0]       s_resp_valid, s_resp_ready;
   logic [RW-1:0]            s_resp_id;
   logic [SW-1:0]            s_resp_status;
   logic [DW-1:0]            s_resp_data;
   logic [RW:0]              outstanding;
   logic                     err_unexpected_resp;

   int checks   = 0;
   int failures = 0;

   // reference model: tag ownership table, output-stage contents, pointer, error flag
   bit               mv   [NTAG];
   int               mown [NTAG];
   logic [RW-1:0]    mid  [NTAG];
   int               mptr;
   bit               mo_valid;
   logic [RW-1:0]    mo_id;
   logic [PAY_W-1:0] mo_pay;
   bit               merr;
   bit               e_load, free_ok, g_ok, hit;
   int               free_t, g_idx;

   cxu_req_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
      .s_req_id(s_req_id), .s_req_payload(s_req_payload),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
      .m_req_id(m_req_id), .m_req_payload(m_req_payload),
      .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
      .m_resp_id(m_resp_id), .m_resp_status(m_resp_status), .m_resp_data(m_resp_data),
      .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
      .s_resp_id(s_resp_id), .s_resp_status(s_resp_status), .s_resp_data(s_resp_data),
      .outstanding(outstanding), .err_unexpected_resp(err_unexpected_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int t = 0; t < NTAG; t++) if (mv[t]) n++;
      return n;
   endfunction

   // expected combinational outputs for the current inputs, compared at negedge
   task automatic model_check();
      logic [NUM_REQ-1:0] e_sreq_rdy;
      logic [NUM_REQ-1:0] e_sresp_v;
      logic               e_mresp_rdy;
      free_ok = 0;
      free_t  = 0;
      for (int t = NTAG-1; t >= 0; t--) if (!mv[t]) begin free_ok = 1; free_t = t; end
      e_load = (!mo_valid || m_req_ready) && free_ok;
      g_ok  = 0;
      g_idx = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!g_ok && s_req_valid[(mptr + k) % NUM_REQ]) begin
            g_ok  = 1;
            g_idx = (mptr + k) % NUM_REQ;
         end
      end
      e_sreq_rdy = '0;
      if (e_load && g_ok) e_sreq_rdy[g_idx] = 1'b1;
      hit = mv[m_resp_id];
      e_sresp_v = '0;
      if (hit && m_resp_valid) e_sresp_v[mown[m_resp_id]] = 1'b1;
      e_mresp_rdy = hit ? s_resp_ready[mown[m_resp_id]] : 1'b1;
      chk("s_req_ready", s_req_ready, e_sreq_rdy);
      chk("m_req_valid", m_req_valid, mo_valid);
      if (mo_valid) begin
         chk("m_req_id", m_req_id, mo_id);
         chk("m_req_payload", m_req_payload, mo_pay);
      end
      chk("s_resp_valid", s_resp_valid, e_sresp_v);
      chk("m_resp_ready", m_resp_ready, e_mresp_rdy);
      if (e_sresp_v != 0) begin
         chk("s_resp_id", s_resp_id, mid[m_resp_id]);
         chk("s_resp_status", s_resp_status, m_resp_status);
         chk("s_resp_data", s_resp_data, m_resp_data);
      end
      chk("outstanding", outstanding, model_count());
      chk("err_unexpected", err_unexpected_resp, merr);
   endtask

   // advance the model by one clock using the inputs seen at the edge
   task automatic model_update();
      bit fr;
      fr = m_resp_valid && hit && s_resp_ready[mown[m_resp_id]];
      if (m_resp_valid && !hit) merr = 1;
      if (!mo_valid || m_req_ready) mo_valid = e_load && g_ok;
      if (e_load && g_ok) begin
         mo_id         = RW'(free_t);
         mo_pay        = s_req_payload[g_idx*PAY_W +: PAY_W];
         mid[free_t]   = s_req_id[g_idx*RW +: RW];
         mown[free_t]  = g_idx;
         mptr          = (g_idx + 1) % NUM_REQ;
      end
      if (fr) mv[m_resp_id] = 0;
      if (e_load && g_ok) mv[free_t] = 1;
   endtask

   task automatic half();
      @(negedge clk);
      model_check();
   endtask

   task automatic edge_();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic cycle();
      half();
      edge_();
   endtask

   task automatic idle();
      s_req_valid   = '0;
      s_req_id      = '0;
      s_req_payload = '0;
      m_req_ready   = 1'b0;
      m_resp_valid  = 1'b0;
      m_resp_id     = '0;
      m_resp_status = '0;
      m_resp_data   = '0;
      s_resp_ready  = '0;
   endtask

   task automatic set_req(input int r, input bit v, input logic [RW-1:0] id, input logic [31:0] d0);
      s_req_valid[r] = v;
      s_req_id[r*RW +: RW] = id;
      s_req_payload[r*PAY_W +: PAY_W] = {4'h1, 2'h2, 10'h5, 32'h1234_0000 + 32'(r), d0, 32'hCAFE_0000 + 32'(r)};
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_m_req_valid", m_req_valid, 1'b0);
      chk("rst_s_req_ready", s_req_ready, 2'b00);
      chk("rst_s_resp_valid", s_resp_valid, 2'b00);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err_unexpected_resp, 1'b0);
      for (int t = 0; t < NTAG; t++) mv[t] = 0;
      mptr     = 0;
      mo_valid = 0;
      merr     = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [127:0] rnd;
      int vq[$];
      idle();
      do_reset();

      // single request and its response
      cycle();
      set_req(0, 1, 3'd5, 32'h11);
      half();
      chk("t1_grant", s_req_ready, 2'b01);
      edge_();
      s_req_valid = '0;
      chk("t1_mvalid", m_req_valid, 1'b1);
      chk("t1_tag", m_req_id, 3'd0);
      chk("t1_data0", m_req_payload[63:32], 32'h11);
      m_req_ready = 1'b1;
      cycle();
      m_req_ready   = 1'b0;
      m_resp_valid  = 1'b1;
      m_resp_id     = 3'd0;
      m_resp_data   = 32'hABCD;
      s_resp_ready  = 2'b11;
      half();
      chk("t1_resp_valid", s_resp_valid, 2'b01);
      chk("t1_resp_id", s_resp_id, 3'd5);
      chk("t1_resp_data", s_resp_data, 32'hABCD);
      chk("t1_out_before", outstanding, 1);
      edge_();
      m_resp_valid = 1'b0;
      half();
      chk("t1_out_after", outstanding, 0);
      edge_();

      // two requesters continuously valid: alternating grants, one per cycle
      idle();
      do_reset();
      set_req(0, 1, 3'd0, 32'hA0);
      set_req(1, 1, 3'd1, 32'hB1);
      m_req_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic [1:0]  eg;
         logic [31:0] ed;
         eg = (k % 2 == 0) ? 2'b01 : 2'b10;
         ed = (k % 2 == 0) ? 32'hA0 : 32'hB1;
         half();
         chk("t2_grant", s_req_ready, eg);
         edge_();
         chk("t2_valid", m_req_valid, 1'b1);
         chk("t2_tag", m_req_id, RW'(k));
         chk("t2_data", m_req_payload[63:32], ed);
      end

      // output stall: stage holds, no readies, pointer holds
      idle();
      do_reset();
      set_req(0, 1, 3'd2, 32'h30);
      cycle();
      set_req(1, 1, 3'd3, 32'h31);
      for (int k = 0; k < 3; k++) begin
         half();
         chk("t3_no_ready", s_req_ready, 2'b00);
         chk("t3_hold_tag", m_req_id, 3'd0);
         chk("t3_hold_data", m_req_payload[63:32], 32'h30);
         edge_();
      end
      m_req_ready = 1'b1;
      half();
      chk("t3_ptr_grant", s_req_ready, 2'b10);
      edge_();
      chk("t3_tag", m_req_id, 3'd1);
      chk("t3_data", m_req_payload[63:32], 32'h31);

      // fill all tags, then free tag 3 and see it reused one cycle later
      idle();
      do_reset();
      m_req_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         set_req(0, 1, RW'(k), 32'(k));
         cycle();
      end
      half();
      chk("t4_full_out", outstanding, 8);
      chk("t4_full_ready", s_req_ready, 2'b00);
      edge_();
      m_resp_valid = 1'b1;
      m_resp_id    = 3'd3;
      s_resp_ready = 2'b11;
      half();
      chk("t4_same_cycle", s_req_ready, 2'b00);
      chk("t4_resp_ready", m_resp_ready, 1'b1);
      edge_();
      m_resp_valid = 1'b0;
      half();
      chk("t4_reuse_ready", s_req_ready, 2'b01);
      chk("t4_out", outstanding, 7);
      edge_();
      chk("t4_reuse_tag", m_req_id, 3'd3);

      // out-of-order responses with a stalled requester
      idle();
      do_reset();
      m_req_ready = 1'b1;
      set_req(0, 1, 3'd2, 32'h50);
      cycle();
      s_req_valid = '0;
      set_req(1, 1, 3'd6, 32'h51);
      cycle();
      s_req_valid = '0;
      cycle();
      m_resp_valid = 1'b1;
      m_resp_id    = 3'd1;
      m_resp_data  = 32'h55;
      s_resp_ready = 2'b01;
      for (int k = 0; k < 2; k++) begin
         half();
         chk("t5_stall_ready", m_resp_ready, 1'b0);
         chk("t5_stall_valid", s_resp_valid, 2'b10);
         edge_();
      end
      s_resp_ready = 2'b11;
      half();
      chk("t5_r1_ready", m_resp_ready, 1'b1);
      chk("t5_r1_valid", s_resp_valid, 2'b10);
      chk("t5_r1_id", s_resp_id, 3'd6);
      edge_();
      m_resp_id   = 3'd0;
      m_resp_data = 32'h66;
      half();
      chk("t5_r0_valid", s_resp_valid, 2'b01);
      chk("t5_r0_id", s_resp_id, 3'd2);
      edge_();
      m_resp_valid = 1'b0;
      half();
      chk("t5_out", outstanding, 0);
      edge_();

      // response to an unallocated tag
      m_resp_valid = 1'b1;
      m_resp_id    = 3'd6;
      half();
      chk("t6_ready", m_resp_ready, 1'b1);
      chk("t6_no_valid", s_resp_valid, 2'b00);
      edge_();
      m_resp_valid = 1'b0;
      half();
      chk("t6_err", err_unexpected_resp, 1'b1);
      edge_();
      cycle();
      half();
      chk("t6_err_held", err_unexpected_resp, 1'b1);
      edge_();

      // random traffic, with an asynchronous reset in the middle
      for (int n = 0; n < 400; n++) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            s_req_valid[r] = rnd[0];
            s_req_id[r*RW +: RW] = rnd[RW+8:9];
            s_req_payload[r*PAY_W +: PAY_W] = rnd[PAY_W-1:0] ^ {$urandom(), 80'h0};
         end
         m_req_ready   = ($urandom_range(3) != 0);
         m_resp_valid  = 1'($urandom_range(1));
         m_resp_status = SW'($urandom_range(1));
         m_resp_data   = $urandom();
         s_resp_ready  = NUM_REQ'($urandom_range(3));
         vq.delete();
         for (int t = 0; t < NTAG; t++) if (mv[t]) vq.push_back(t);
         if (vq.size() > 0 && $urandom_range(3) != 0)
            m_resp_id = RW'(vq[$urandom_range(vq.size()-1)]);
         else
            m_resp_id = RW'($urandom_range(NTAG-1));
         if (n == 250) do_reset();
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
